// File: rtl/serial_bus_pkg.sv
// Shared types and default widths for the serial bus slave.
package serial_bus_pkg;

  localparam int ADDR_LEN_DEF        = 12;
  localparam int DATA_LEN_DEF        = 8;
  localparam int BURST_LEN_DEF       = 12;
  localparam int MEM_ADDR_W_DEF      = 11;
  localparam int SPLIT_THRESHOLD_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RWAIT,
    FETCH,
    RTX
  } slave_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous RAM, one-cycle read latency, contents survive reset.
module slave_bram #(
  parameter int DATA_LEN = 8,
  parameter int ADDR_W   = 11
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem [2**ADDR_W];
  logic [DATA_LEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/serial_bus_slave_mem.sv
// Memory-backed serial bus responder: deserialises address/burst/write data,
// stores beats in RAM and serialises read beats back LSB first.
module serial_bus_slave_mem
  import serial_bus_pkg::*;
#(
  parameter int ADDR_LEN        = ADDR_LEN_DEF,
  parameter int DATA_LEN        = DATA_LEN_DEF,
  parameter int BURST_LEN       = BURST_LEN_DEF,
  parameter int MEM_ADDR_W      = MEM_ADDR_W_DEF,
  parameter int SPLIT_THRESHOLD = SPLIT_THRESHOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] slave_delay,
  input  logic       read_en,
  input  logic       write_en,
  input  logic       master_valid,
  input  logic       master_ready,
  input  logic       rx_address,
  input  logic       rx_burst,
  input  logic       rx_data,
  output logic       tx_data,
  output logic       slave_valid,
  output logic       slave_ready,
  output logic       split_en
);

  localparam int CNT_W = $clog2(max2(ADDR_LEN, DATA_LEN) + 1);

  slave_state_t          state_q, state_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [BURST_LEN-1:0]  beat_q, beat_d;
  logic [BURST_LEN-1:0]  burst_q, burst_d;
  logic [5:0]            wait_q, wait_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0]   wbuf_q, wbuf_d;
  logic                  long_q, long_d;

  logic                  ram_we, ram_re;
  logic [MEM_ADDR_W-1:0] ram_idx;
  logic [DATA_LEN-1:0]   ram_rdata;
  logic                  cap_addr, cap_data, abort, last_beat, tx_bit;

  assign abort     = !read_en && !write_en;
  // A zero burst field still moves one beat.
  assign last_beat = (burst_q == '0) || (beat_q == burst_q - 1'b1);
  assign ram_idx   = addr_q + MEM_ADDR_W'(beat_q);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    wbuf_d   = wbuf_q;
    long_d   = long_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    cap_addr = 1'b0;
    cap_data = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      beat_d   = '0;
      long_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (master_valid && (read_en ^ write_en)) begin
            state_d  = ADDR;
            addr_d   = '0;
            burst_d  = '0;
            beat_d   = '0;
            cap_addr = 1'b1;
            bitcnt_d = CNT_W'(1);
          end
        end
        ADDR: begin
          if (master_valid) begin
            cap_addr = 1'b1;
            if (bitcnt_q == CNT_W'(ADDR_LEN - 1)) begin
              bitcnt_d = '0;
              if (write_en) begin
                state_d = WDATA;
              end else if (slave_delay == '0) begin
                state_d = FETCH;
              end else begin
                state_d = RWAIT;
                wait_d  = slave_delay;
                long_d  = (slave_delay >= 6'(SPLIT_THRESHOLD));
              end
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
        WDATA: begin
          if (master_valid) begin
            cap_data = 1'b1;
            if (bitcnt_q == CNT_W'(DATA_LEN - 1)) begin
              bitcnt_d = '0;
              state_d  = WRITE;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          ram_we = 1'b1;
          if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            state_d = WDATA;
            beat_d  = beat_q + 1'b1;
          end
        end
        RWAIT: begin
          wait_d = wait_q - 1'b1;
          if (wait_q == 6'd1) begin
            state_d = FETCH;
            long_d  = 1'b0;
          end
        end
        FETCH: begin
          ram_re   = 1'b1;
          bitcnt_d = '0;
          state_d  = RTX;
        end
        RTX: begin
          if (master_ready) begin
            if (bitcnt_q == CNT_W'(DATA_LEN - 1)) begin
              bitcnt_d = '0;
              if (last_beat) begin
                state_d = IDLE;
                beat_d  = '0;
              end else begin
                state_d = FETCH;
                beat_d  = beat_q + 1'b1;
              end
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Bits land at their LSB-first position; address bits above the RAM index are dropped.
    if (cap_addr) begin
      for (int i = 0; i < MEM_ADDR_W; i++)
        if (bitcnt_q == CNT_W'(i)) addr_d[i] = rx_address;
      for (int i = 0; i < BURST_LEN; i++)
        if (bitcnt_q == CNT_W'(i)) burst_d[i] = rx_burst;
    end
    if (cap_data) begin
      for (int i = 0; i < DATA_LEN; i++)
        if (bitcnt_q == CNT_W'(i)) wbuf_d[i] = rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      beat_q   <= '0;
      burst_q  <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      wbuf_q   <= '0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      wbuf_q   <= wbuf_d;
      long_q   <= long_d;
    end
  end

  slave_bram #(
    .DATA_LEN (DATA_LEN),
    .ADDR_W   (MEM_ADDR_W)
  ) u_bram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_idx),
    .wdata (wbuf_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    tx_bit = 1'b0;
    for (int i = 0; i < DATA_LEN; i++)
      if (bitcnt_q == CNT_W'(i)) tx_bit = ram_rdata[i];
  end

  // RAM output register holds between FETCHes, so tx_data stays stable while stalled.
  assign tx_data     = (state_q == RTX) && tx_bit;
  assign slave_valid = (state_q == RTX);
  assign slave_ready = rst && (state_q == IDLE || state_q == ADDR || state_q == WDATA);
  assign split_en    = (state_q == RWAIT) && long_q;

endmodule

// File: tb/tb_serial_bus_slave_mem.sv
// Randomised bench for serial_bus_slave_mem with a flat-array memory model.
module tb_serial_bus_slave_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] slave_delay = '0;
  logic       read_en = 1'b0, write_en = 1'b0, master_valid = 1'b0, master_ready = 1'b0;
  logic       rx_address = 1'b0, rx_burst = 1'b0, rx_data = 1'b0;
  logic       tx_data, slave_valid, slave_ready, split_en;

  serial_bus_slave_mem dut (
    .clk          (clk),
    .rst          (rst),
    .slave_delay  (slave_delay),
    .read_en      (read_en),
    .write_en     (write_en),
    .master_valid (master_valid),
    .master_ready (master_ready),
    .rx_address   (rx_address),
    .rx_burst     (rx_burst),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .slave_valid  (slave_valid),
    .slave_ready  (slave_ready),
    .split_en     (split_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0, n_bad = 0;
  bit         stall_en = 1'b0;
  logic [7:0] mem_m [2048];
  logic [7:0] wdat [16];
  logic [7:0] rd_q [$];
  int         first_lat, split_cnt, rdy_low, vcnt, last_bit_cyc;
  logic       rd_bits [$];

  task automatic send_bit(input logic a, input logic b, input logic d);
    int guard = 0;
    forever begin
      @(negedge clk);
      if (slave_ready && (!stall_en || $urandom_range(0, 3) != 0)) begin
        master_valid = 1'b1; rx_address = a; rx_burst = b; rx_data = d;
        last_bit_cyc = cyc;
        break;
      end
      master_valid = 1'b0;
      guard++;
      if (guard > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_bit: slave_ready stuck at %b, wanted 1", slave_ready);
        break;
      end
    end
  endtask

  task automatic send_addr(input logic [11:0] a, input logic [11:0] bf);
    for (int i = 0; i < 12; i++) send_bit(a[i], bf[i], 1'b0);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [11:0] bf);
    int nb = (bf == 0) ? 1 : int'(bf);
    read_en = 1'b0; write_en = 1'b1;
    send_addr(a, bf);
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, wdat[k][i]);
      mem_m[(int'(a) + k) % 2048] = wdat[k];
    end
    @(negedge clk); master_valid = 1'b0;
    @(negedge clk); write_en = 1'b0;
  endtask

  // mode 0: master_ready always 1; 1: pattern 1,0,0,1; 2: random
  task automatic do_read(input logic [11:0] a, input logic [11:0] bf, input int dly, input int mode);
    int nb = (bf == 0) ? 1 : int'(bf);
    int got = 0, guard = 0, p = 0, t0;
    logic prev_hold = 1'b0, prev_tx = 1'b0, mr;
    logic [7:0] byt;
    rd_q.delete(); rd_bits.delete();
    first_lat = -1; split_cnt = 0; rdy_low = 0; vcnt = 0;
    write_en = 1'b0; read_en = 1'b1; slave_delay = 6'(dly);
    send_addr(a, bf);
    t0 = last_bit_cyc;
    while (got < nb * 8 && guard < 3000) begin
      @(negedge clk);
      master_valid = 1'b0;
      guard++;
      if (split_en) split_cnt++;
      if (first_lat < 0 && !slave_valid && !slave_ready) rdy_low++;
      if (prev_hold) begin
        n_cmp++;
        if (!slave_valid || tx_data !== prev_tx) begin
          n_bad++;
          $display("FAIL hold: valid=%b tx=%b, wanted valid=1 tx=%b", slave_valid, tx_data, prev_tx);
        end
      end
      if (slave_valid) begin
        if (first_lat < 0) first_lat = cyc - t0;
        vcnt++;
        case (mode)
          0:       mr = 1'b1;
          1:       mr = (p % 4 == 0) || (p % 4 == 3);
          default: mr = 1'($urandom_range(0, 1));
        endcase
        p++;
        master_ready = mr;
        if (mr) begin rd_bits.push_back(tx_data); got++; end
        prev_hold = !mr; prev_tx = tx_data;
      end else begin
        master_ready = 1'($urandom_range(0, 1));
        prev_hold = 1'b0;
      end
    end
    if (got < nb * 8) begin
      n_cmp++; n_bad++;
      $display("FAIL read_timeout: got %0d bits, wanted %0d", got, nb * 8);
    end
    @(negedge clk);
    n_cmp++;
    if (slave_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL read_exit: slave_valid=%b after last bit, wanted 0", slave_valid);
    end
    master_ready = 1'b0; read_en = 1'b0;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < 8; i++) byt[i] = (8 * k + i < rd_bits.size()) ? rd_bits[8 * k + i] : 1'bx;
      rd_q.push_back(byt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (slave_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b wanted 0", slave_valid); end
    n_cmp++; if (split_en !== 1'b0) begin n_bad++; $display("FAIL rst_split: got %b wanted 0", split_en); end
    n_cmp++; if (tx_data !== 1'b0) begin n_bad++; $display("FAIL rst_tx: got %b wanted 0", tx_data); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (slave_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b wanted 1", slave_ready); end
  endtask

  task automatic test_single();
    logic [7:0] exp_bits = 8'hA5;
    wdat[0] = 8'hA5;
    do_write(12'h005, 12'd1);
    do_read(12'h005, 12'd1, 0, 0);
    n_cmp++; if (vcnt != 8) begin n_bad++; $display("FAIL single_vcnt: got %0d wanted 8", vcnt); end
    n_cmp++; if (first_lat != 2) begin n_bad++; $display("FAIL single_lat: got %0d wanted 2", first_lat); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd_bits.size() <= i || rd_bits[i] !== exp_bits[i]) begin
        n_bad++; $display("FAIL single_bit%0d: got %b wanted %b", i, (rd_bits.size() > i) ? rd_bits[i] : 1'bx, exp_bits[i]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) wdat[k] = 8'(k + 1);
    do_write(12'h7FE, 12'd4);
    do_read(12'h7FE, 12'd4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rd_q[k] !== 8'(k + 1)) begin n_bad++; $display("FAIL wrap_beat%0d: got %h wanted %h", k, rd_q[k], 8'(k + 1)); end
    end
    do_read(12'h000, 12'd2, 0, 0);
    n_cmp++; if (rd_q[0] !== 8'h03) begin n_bad++; $display("FAIL wrap_idx0: got %h wanted 03", rd_q[0]); end
    n_cmp++; if (rd_q[1] !== 8'h04) begin n_bad++; $display("FAIL wrap_idx1: got %h wanted 04", rd_q[1]); end
  endtask

  task automatic test_split();
    int dl [3] = '{10, 7, 8};
    for (int j = 0; j < 3; j++) begin
      do_read(12'h005, 12'd1, dl[j], 2);
      n_cmp++; if (split_cnt != ((dl[j] >= 8) ? dl[j] : 0)) begin n_bad++; $display("FAIL split_cnt d=%0d: got %0d wanted %0d", dl[j], split_cnt, (dl[j] >= 8) ? dl[j] : 0); end
      n_cmp++; if (rdy_low != dl[j] + 1) begin n_bad++; $display("FAIL split_rdylow d=%0d: got %0d wanted %0d", dl[j], rdy_low, dl[j] + 1); end
      n_cmp++; if (first_lat != dl[j] + 2) begin n_bad++; $display("FAIL split_lat d=%0d: got %0d wanted %0d", dl[j], first_lat, dl[j] + 2); end
      n_cmp++; if (rd_q[0] !== 8'hA5) begin n_bad++; $display("FAIL split_data d=%0d: got %h wanted a5", dl[j], rd_q[0]); end
    end
  endtask

  task automatic test_ready_toggle();
    wdat[0] = 8'h3C;
    do_write(12'h03C, 12'd1);
    do_read(12'h03C, 12'd1, 0, 1);
    n_cmp++; if (rd_q[0] !== 8'h3C) begin n_bad++; $display("FAIL toggle_data: got %h wanted 3c", rd_q[0]); end
  endtask

  task automatic test_reset_mid();
    wdat[0] = 8'h77;
    do_write(12'h101, 12'd1);
    read_en = 1'b0; write_en = 1'b1;
    send_addr(12'h100, 12'd3);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, 1'(8'h11 >> i));
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'(8'h22 >> i));
    mem_m[12'h100] = 8'h11;
    @(negedge clk);
    rst = 1'b0; master_valid = 1'b0; write_en = 1'b0;
    #1;
    n_cmp++; if (slave_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b wanted 0", slave_ready); end
    n_cmp++; if (slave_valid !== 1'b0 || split_en !== 1'b0 || tx_data !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outs: valid=%b split=%b tx=%b wanted 0 0 0", slave_valid, split_en, tx_data);
    end
    @(negedge clk); rst = 1'b1;
    do_read(12'h100, 12'd2, 0, 2);
    n_cmp++; if (rd_q[0] !== 8'h11) begin n_bad++; $display("FAIL midrst_beat1: got %h wanted 11", rd_q[0]); end
    n_cmp++; if (rd_q[1] !== 8'h77) begin n_bad++; $display("FAIL midrst_beat2: got %h wanted 77", rd_q[1]); end
  endtask

  task automatic test_corner();
    // both enables high: must stay idle and leave later transactions aligned
    read_en = 1'b1; write_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_cmp++; if (slave_ready !== 1'b1) begin n_bad++; $display("FAIL both_ready cyc%0d: got %b wanted 1", i, slave_ready); end
      master_valid = 1'b1; rx_address = 1'($urandom); rx_burst = 1'($urandom); rx_data = 1'($urandom);
    end
    @(negedge clk); master_valid = 1'b0; write_en = 1'b0;
    do_read(12'h005, 12'd1, 0, 0);
    n_cmp++; if (rd_q[0] !== 8'hA5) begin n_bad++; $display("FAIL both_after: got %h wanted a5", rd_q[0]); end
    // zero burst field moves exactly one beat
    wdat[0] = 8'h44; do_write(12'h301, 12'd1);
    wdat[0] = 8'h9C; wdat[1] = 8'hEE; do_write(12'h300, 12'd0);
    do_read(12'h300, 12'd2, 0, 0);
    n_cmp++; if (rd_q[0] !== 8'h9C) begin n_bad++; $display("FAIL burst0_beat: got %h wanted 9c", rd_q[0]); end
    n_cmp++; if (rd_q[1] !== 8'h44) begin n_bad++; $display("FAIL burst0_next: got %h wanted 44", rd_q[1]); end
    do_read(12'h300, 12'd0, 0, 0);
    n_cmp++; if (vcnt != 8) begin n_bad++; $display("FAIL burst0_rd_vcnt: got %0d wanted 8", vcnt); end
    // enables dropped mid-address
    wdat[0] = 8'h5A; do_write(12'h200, 12'd1);
    read_en = 1'b0; write_en = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'(12'h200 >> i), 1'(i == 0), 1'b1);
    @(negedge clk); master_valid = 1'b0; write_en = 1'b0;
    @(negedge clk);
    do_read(12'h200, 12'd1, 0, 0);
    n_cmp++; if (rd_q[0] !== 8'h5A) begin n_bad++; $display("FAIL abort_addr: got %h wanted 5a", rd_q[0]); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    int nb, dly;
    stall_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      a = 12'($urandom);
      nb = $urandom_range(1, 4);
      dly = $urandom_range(0, 12);
      for (int k = 0; k < nb; k++) wdat[k] = 8'($urandom);
      do_write(a, 12'(nb));
      do_read(a, 12'(nb), dly, 2);
      n_cmp++; if (first_lat != dly + 2) begin n_bad++; $display("FAIL rand%0d_lat: got %0d wanted %0d", t, first_lat, dly + 2); end
      for (int k = 0; k < nb; k++) begin
        n_cmp++;
        if (rd_q[k] !== mem_m[(int'(a) + k) % 2048]) begin
          n_bad++; $display("FAIL rand%0d_beat%0d: got %h wanted %h", t, k, rd_q[k], mem_m[(int'(a) + k) % 2048]);
        end
      end
    end
    stall_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_split();
    test_ready_toggle();
    test_reset_mid();
    test_corner();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
